// File: rtl/bit_population_counter_iter_if.sv
// Producer/consumer bundle for the iterative population counter.
// Handshake: a word transfers on a rising edge where data_val_i and data_ready_o are both 1;
// data_val_o is a one-cycle pulse marking a fresh data_o and has no ready (the consumer cannot stall it).
interface bit_population_counter_iter_if #(
    parameter int WIDTH = 16
);
    localparam int OUT_W = $clog2(WIDTH) + 1;

    logic [WIDTH-1:0] data_i;
    logic             data_val_i;
    logic             count_zeros_i;
    logic             data_ready_o;
    logic [OUT_W-1:0] data_o;
    logic             data_val_o;
    logic             state_dbg;

    modport master (
        output data_i, data_val_i, count_zeros_i,
        input  data_ready_o, data_o, data_val_o, state_dbg
    );

    modport slave (
        input  data_i, data_val_i, count_zeros_i,
        output data_ready_o, data_o, data_val_o, state_dbg
    );
endinterface

// File: rtl/bit_population_counter_iter.sv
// Iterative popcount: latches one word, sums CHUNK bits per clock, pulses the total.
// Zero-count mode inverts before padding so pad bits never contribute.
module bit_population_counter_iter #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic clk_i,
    input  logic arstn_i,
    bit_population_counter_iter_if.slave bus
);
    localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK;
    localparam int PAD_W  = NCHUNK * CHUNK;
    localparam int OUT_W  = $clog2(WIDTH) + 1;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    state_t           state;
    logic [PAD_W-1:0] shreg;
    logic [OUT_W-1:0] acc;
    logic [IDX_W-1:0] idx;
    logic [OUT_W-1:0] result;
    logic             result_val;
    logic [OUT_W-1:0] chunk_cnt;
    logic [WIDTH-1:0] word;

    assign word = bus.count_zeros_i ? ~bus.data_i : bus.data_i;

    // The current chunk always sits in the low CHUNK bits of the shift register.
    always_comb begin
        chunk_cnt = '0;
        for (int i = 0; i < CHUNK; i++) begin
            chunk_cnt = chunk_cnt + OUT_W'(shreg[i]);
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state      <= IDLE;
            shreg      <= '0;
            acc        <= '0;
            idx        <= '0;
            result     <= '0;
            result_val <= 1'b0;
        end else begin
            result_val <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.data_val_i) begin
                        shreg <= PAD_W'(word);
                        acc   <= '0;
                        idx   <= '0;
                        state <= COUNT;
                    end
                end
                COUNT: begin
                    acc   <= acc + chunk_cnt;
                    idx   <= idx + IDX_W'(1);
                    shreg <= shreg >> CHUNK;
                    if (idx == IDX_W'(NCHUNK - 1)) begin
                        result     <= acc + chunk_cnt;
                        result_val <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.data_ready_o = (state == IDLE);
    assign bus.data_o       = result;
    assign bus.data_val_o   = result_val;
    assign bus.state_dbg    = state;
endmodule
